// File: rtl/mips_run_ctrl_if.sv
// Bus between the run controller and whatever launches runs (board logic or bench).
// Optional PC trace port is present only when MIPS_RUN_TRACE_EN is defined.
//
// Handshake: start is a one-cycle request with no ready/ack. The controller samples it
// on every rising edge and acts on it only in IDLE or DONE. A start seen in RESET or
// RUN is dropped and not remembered. pc is sampled on every rising edge while in RUN.
interface mips_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [31:0]      pc;
  logic             core_rst;
  logic             running;
  logic             done;
  logic             halted;
  logic             timed_out;
  logic [CNT_W-1:0] cycle_cnt;
  logic [1:0]       state_dbg;
`ifdef MIPS_RUN_TRACE_EN
  logic [2:0]       trace_idx;
  logic [31:0]      trace_pc;
`endif

`ifdef MIPS_RUN_TRACE_EN
  modport master (
    output start, pc, trace_idx,
    input  core_rst, running, done, halted, timed_out, cycle_cnt, state_dbg, trace_pc
  );
  modport slave (
    input  start, pc, trace_idx,
    output core_rst, running, done, halted, timed_out, cycle_cnt, state_dbg, trace_pc
  );
`else
  modport master (
    output start, pc,
    input  core_rst, running, done, halted, timed_out, cycle_cnt, state_dbg
  );
  modport slave (
    input  start, pc,
    output core_rst, running, done, halted, timed_out, cycle_cnt, state_dbg
  );
`endif
endinterface

// File: rtl/mips_run_ctrl.sv
// Run controller for the MIPS core: holds the core in reset, releases it for a run,
// counts run cycles and stops the run on halt PC, self-loop or timeout.
// Optional feature macro: MIPS_RUN_TRACE_EN adds an 8-entry PC history with a read port.
module mips_run_ctrl #(
  parameter int          RST_CYCLES  = 4,
  parameter int          CNT_W       = 32,
  parameter longint      MAX_CYCLES  = 1000,
  parameter logic [31:0] HALT_PC     = 32'h0000_3FFC,
  parameter int          STALL_LIMIT = 3
) (
  input logic            clk,
  input logic            rst,
  mips_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  // Holds values up to STALL_LIMIT-1, the count reached on the halting sample.
  localparam int ST_W = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;

  localparam logic [RC_W-1:0]  RST_LAST   = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MAX_CYCLES - 1);
  // Stall count held before the sample that completes STALL_LIMIT equal PCs.
  localparam logic [ST_W-1:0]  STALL_LAST = ST_W'(STALL_LIMIT - 2);

  state_t           state_q,     state_d;
  logic [RC_W-1:0]  rst_cnt_q,   rst_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [ST_W-1:0]  stall_q,     stall_d;
  logic [31:0]      last_pc_q,   last_pc_d;
  logic             first_q,     first_d;
  logic             halted_q,    halted_d;
  logic             timed_out_q, timed_out_d;

  logic launch;
  logic pc_same;
  logic halt_hit;
  logic timeout_hit;

  // A start is honoured only when no run is in progress.
  assign launch = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // The first RUN sample has no meaningful predecessor, so it never counts as a repeat.
  assign pc_same     = !first_q && (bus.pc == last_pc_q);
  assign halt_hit    = (bus.pc == HALT_PC) || (pc_same && (stall_q == STALL_LAST));
  assign timeout_hit = (cycle_cnt_q == CNT_LAST);

  // Next-state and next-register logic; a launch overrides whatever the case decided.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    stall_d     = stall_q;
    last_pc_d   = last_pc_q;
    first_d     = first_q;
    halted_d    = halted_q;
    timed_out_d = timed_out_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
        last_pc_d = bus.pc;
        first_d   = 1'b0;
        stall_d   = pc_same ? stall_q + 1'b1 : '0;
        // Halt is checked first so a halt on the last allowed cycle is not a timeout.
        if (halt_hit) begin
          state_d  = S_DONE;
          halted_d = 1'b1;
        end else if (timeout_hit) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (launch) begin
      state_d     = S_RESET;
      rst_cnt_d   = '0;
      cycle_cnt_d = '0;
      stall_d     = '0;
      last_pc_d   = '0;
      first_d     = 1'b1;
      halted_d    = 1'b0;
      timed_out_d = 1'b0;
    end
  end

  // State and datapath registers; rst aborts any run immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      cycle_cnt_q <= '0;
      stall_q     <= '0;
      last_pc_q   <= '0;
      first_q     <= 1'b1;
      halted_q    <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_q     <= stall_d;
      last_pc_q   <= last_pc_d;
      first_q     <= first_d;
      halted_q    <= halted_d;
      timed_out_q <= timed_out_d;
    end
  end

  // The core is frozen in every state except RUN.
  assign bus.core_rst  = (state_q != S_RUN);
  assign bus.running   = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.halted    = halted_q;
  assign bus.timed_out = timed_out_q;
  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.state_dbg = state_q;

`ifdef MIPS_RUN_TRACE_EN
  logic [31:0] trace_q [8];
  logic [2:0]  wr_ptr_q;
  logic [2:0]  rd_ptr;

  // PC history ring: one entry per RUN cycle, wiped whenever a new run is launched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        trace_q[i] <= '0;
      end
      wr_ptr_q <= '0;
    end else if (launch) begin
      for (int i = 0; i < 8; i++) begin
        trace_q[i] <= '0;
      end
      wr_ptr_q <= '0;
    end else if (state_q == S_RUN) begin
      trace_q[wr_ptr_q] <= bus.pc;
      wr_ptr_q          <= wr_ptr_q + 3'd1;
    end
  end

  // Newest entry sits just behind the write pointer; index counts backwards from it.
  assign rd_ptr       = wr_ptr_q - 3'd1 - bus.trace_idx;
  assign bus.trace_pc = trace_q[rd_ptr];
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: randomized runs checked every cycle against a behavioural
// model built on the list of PCs sampled during the current run.
module tb_mips_run_ctrl;

  localparam int          RST_CYCLES  = 4;
  localparam int          CNT_W       = 32;
  localparam int          MAX_CYCLES  = 50;
  localparam logic [31:0] HALT_PC     = 32'h0000_3FFC;
  localparam int          STALL_LIMIT = 3;
  localparam int          EXP_W       = CNT_W + 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mips_run_ctrl #(
    .RST_CYCLES (RST_CYCLES),
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES),
    .HALT_PC    (HALT_PC),
    .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_RESET, M_RUN, M_DONE} mphase_t;
  mphase_t     m_phase    = M_IDLE;
  int          m_rst_left = 0;
  bit          m_halted   = 1'b0;
  bit          m_timed    = 1'b0;
  logic [31:0] hist[$];   // PCs sampled in RUN during the current run, oldest first

  function automatic bit loop_seen();
    int n;
    n = hist.size();
    if (n < STALL_LIMIT) return 1'b0;
    for (int j = 1; j < STALL_LIMIT; j++)
      if (hist[n-1-j] != hist[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_launch();
    m_phase    = M_RESET;
    m_rst_left = RST_CYCLES;
    m_halted   = 1'b0;
    m_timed    = 1'b0;
    hist.delete();
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase  = M_IDLE;
      m_halted = 1'b0;
      m_timed  = 1'b0;
      hist.delete();
    end else begin
      case (m_phase)
        M_IDLE:  if (bus.start) model_launch();
        M_RESET: begin
          m_rst_left--;
          if (m_rst_left == 0) m_phase = M_RUN;
        end
        M_RUN: begin
          hist.push_back(bus.pc);
          if (bus.pc == HALT_PC || loop_seen()) begin
            m_phase  = M_DONE;
            m_halted = 1'b1;
          end else if (hist.size() == MAX_CYCLES) begin
            m_phase = M_DONE;
            m_timed = 1'b1;
          end
        end
        M_DONE:  if (bus.start) model_launch();
        default: m_phase = M_IDLE;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] e;

  always @(posedge clk) begin
    #1;
    exp_q.push_back({m_phase != M_RUN, m_phase == M_RUN, m_phase == M_DONE,
                     m_halted, m_timed, CNT_W'(hist.size())});
  end

  always @(posedge clk) begin
    #2;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard_empty: got 0 entries want 1 at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("core_rst",  bus.core_rst,  e[CNT_W+4]);
      check("running",   bus.running,   e[CNT_W+3]);
      check("done",      bus.done,      e[CNT_W+2]);
      check("halted",    bus.halted,    e[CNT_W+1]);
      check("timed_out", bus.timed_out, e[CNT_W]);
      check("cycle_cnt", bus.cycle_cnt, e[CNT_W-1:0]);
`ifdef MIPS_RUN_TRACE_EN
      check("trace_pc", bus.trace_pc,
            (int'(bus.trace_idx) < hist.size()) ? hist[hist.size()-1-int'(bus.trace_idx)] : 32'h0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge where the core has just entered RUN.
  task automatic launch(input bit check_hold);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (check_hold) begin
      check("launch_done_clear",   bus.done,      1'b0);
      check("launch_halted_clear", bus.halted,    1'b0);
      check("launch_cnt_clear",    bus.cycle_cnt, 32'd0);
    end
    for (int i = 0; i < RST_CYCLES; i++) begin
      if (check_hold) begin
        check("hold_core_rst", bus.core_rst, 1'b1);
        check("hold_running",  bus.running,  1'b0);
      end
      bus.start = ($urandom_range(0, 1) == 1);   // must be ignored in RESET
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (check_hold) begin
      check("run_after_hold",     bus.running,  1'b1);
      check("core_rst_after_hold", bus.core_rst, 1'b0);
    end
  endtask

  // Drives one PC per RUN cycle. halt_at / stall_from are 1-based run cycles (0 = off).
  task automatic drive_run(input int halt_at, input int stall_from, input logic [31:0] stall_val,
                           input bit rand_pc, input int budget, input bit expect_done);
    logic [31:0] prev;
    int          k;
    prev = 32'h0;
    for (int i = 0; i < budget && m_phase != M_DONE; i++) begin
      k = hist.size() + 1;
      if (halt_at == k)                        bus.pc = HALT_PC;
      else if (stall_from != 0 && k >= stall_from) bus.pc = stall_val;
      else if (rand_pc)
        bus.pc = ($urandom_range(0, 3) == 0) ? prev : prev + 32'(4 * $urandom_range(1, 4));
      else                                     bus.pc = 32'(4 * (k - 1));
      prev      = bus.pc;
      bus.start = ($urandom_range(0, 9) == 0);   // must be ignored in RUN
`ifdef MIPS_RUN_TRACE_EN
      bus.trace_idx = 3'($urandom_range(0, 7));
`endif
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (expect_done) check("run_finished", bus.done, 1'b1);
  endtask

  // Asynchronous abort: outputs must fall to reset values without waiting for a clock.
  task automatic abort_run();
    rst = 1'b1;
    #1;
    check("abort_core_rst", bus.core_rst,  1'b1);
    check("abort_running",  bus.running,   1'b0);
    check("abort_cnt",      bus.cycle_cnt, 32'd0);
    check("abort_done",     bus.done,      1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.pc    = 32'h0;
`ifdef MIPS_RUN_TRACE_EN
    bus.trace_idx = 3'd0;
`endif
    repeat (2) @(negedge clk);
    check("rst_core_rst", bus.core_rst,  1'b1);
    check("rst_done",     bus.done,      1'b0);
    check("rst_cnt",      bus.cycle_cnt, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_core_rst", bus.core_rst, 1'b1);
    check("idle_running",  bus.running,  1'b0);
    check("idle_done",     bus.done,     1'b0);

    // Halt PC at run cycle 10 with PC stepping +4 from 0.
    launch(1'b1);
    drive_run(10, 0, 32'h0, 1'b0, 100, 1'b1);
    check("halt_halted", bus.halted,    1'b1);
    check("halt_timed",  bus.timed_out, 1'b0);
    check("halt_cnt",    bus.cycle_cnt, 32'd10);
`ifdef MIPS_RUN_TRACE_EN
    for (int idx = 0; idx < 8; idx++) begin
      bus.trace_idx = 3'(idx);
      #1;
      check("trace_lit", bus.trace_pc, (idx == 0) ? 32'h3FFC : 32'(4 * (9 - idx)));
      @(negedge clk);
    end
`endif

    // Self-loop: PC held at 0x20 from run cycle 5; third equal sample ends the run.
    launch(1'b1);
    drive_run(0, 5, 32'h0000_0020, 1'b0, 100, 1'b1);
    check("loop_halted", bus.halted,    1'b1);
    check("loop_cnt",    bus.cycle_cnt, 32'd7);

    // Timeout with an ever-changing PC.
    launch(1'b1);
    drive_run(0, 0, 32'h0, 1'b0, 100, 1'b1);
    check("tmo_timed",  bus.timed_out, 1'b1);
    check("tmo_halted", bus.halted,    1'b0);
    check("tmo_cnt",    bus.cycle_cnt, 32'd50);

    // Halt on the last allowed cycle: halt takes precedence.
    launch(1'b1);
    drive_run(MAX_CYCLES, 0, 32'h0, 1'b0, 100, 1'b1);
    check("tie_halted", bus.halted,    1'b1);
    check("tie_timed",  bus.timed_out, 1'b0);
    check("tie_cnt",    bus.cycle_cnt, 32'd50);

    // Abort mid-run, then restart from IDLE.
    launch(1'b1);
    drive_run(0, 0, 32'h0, 1'b0, 6, 1'b0);
    abort_run();

    // Randomized runs, occasionally aborted.
    for (int r = 0; r < 24; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      launch(1'b1);
      if (r % 7 == 3) begin
        drive_run(0, 0, 32'h0, 1'b1, $urandom_range(1, 20), 1'b0);
        abort_run();
      end else begin
        drive_run(($urandom_range(0, 1) == 1) ? $urandom_range(1, 70) : 0,
                  ($urandom_range(0, 1) == 1) ? $urandom_range(2, 40) : 0,
                  $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(0, 1) == 1), 100, 1'b1);
      end
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
